game_timer_ctrl: RTL and testbench

//  Sequences game time-keeping for the sudoku top level: start/pause/resume/solve/abort FSM.

---
 rtl/game_timer_ctrl_pkg.sv | 22 ++
 rtl/game_timer_ctrl_tick_prescaler.sv | 30 +++
 rtl/game_timer_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_timer_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_ctrl_pkg.sv
// Shared state codes, widths and helpers for the game timer controller.
package game_timer_ctrl_pkg;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 5;
  localparam int unsigned TIMER_W = 11;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_SOLVED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // Total elapsed seconds at which a game with the given minute limit times out.
  function automatic logic [TIMER_W-1:0] limit_seconds(input int unsigned lim_min);
    return TIMER_W'(lim_min * 60);
  endfunction

endpackage

// File: rtl/game_timer_ctrl_tick_prescaler.sv
// Free-running 1 Hz clock-enable generator; wrap flags the last cycle of each second.
module tick_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic wrap
);

  localparam int unsigned CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Combinational so the top can register the tick on the wrapping edge.
  assign wrap = en && !clear && (r_cnt == LAST);

endmodule

// File: rtl/game_timer_ctrl.sv
// Game time-keeping: start/pause/solve/abort FSM, MM:SS counters, timeout and best time.
module game_timer_ctrl
  import game_timer_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned LIMIT_MIN = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause_toggle,
  input  logic               solved,
  input  logic               abort,
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic               tick,
  output logic [SEC_W-1:0]   seconds,
  output logic [MIN_W-1:0]   minutes,
  output logic [TIMER_W-1:0] timer,
  output logic               timeout,
  output logic               best_valid,
  output logic [TIMER_W-1:0] best_time
);

  localparam logic [TIMER_W-1:0] LIMIT_T = limit_seconds(LIMIT_MIN);
  localparam logic [SEC_W-1:0]   SEC_MAX = SEC_W'(59);

  state_t             r_state,      w_state_nxt;
  logic               r_running,    w_running_nxt;
  logic               r_tick,       w_tick_nxt;
  logic [SEC_W-1:0]   r_seconds,    w_seconds_nxt;
  logic [MIN_W-1:0]   r_minutes,    w_minutes_nxt;
  logic [TIMER_W-1:0] r_timer,      w_timer_nxt;
  logic               r_timeout,    w_timeout_nxt;
  logic               r_best_valid, w_best_valid_nxt;
  logic [TIMER_W-1:0] r_best_time,  w_best_time_nxt;

  logic w_wrap;
  logic w_start_ok;
  logic w_solve_ok;
  logic w_pres_clear;
  logic w_pres_en;

  assign w_start_ok   = start && (r_state inside {ST_IDLE, ST_SOLVED, ST_TIMEOUT});
  assign w_solve_ok   = solved && (r_state inside {ST_RUNNING, ST_PAUSED});
  assign w_pres_clear = abort || w_start_ok;
  assign w_pres_en    = (r_state == ST_RUNNING);

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_pres_en),
    .clear   (w_pres_clear),
    .wrap    (w_wrap)
  );

  // State and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_tick       <= 1'b0;
      r_seconds    <= '0;
      r_minutes    <= '0;
      r_timer      <= '0;
      r_timeout    <= 1'b0;
      r_best_valid <= 1'b0;
      r_best_time  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_running    <= w_running_nxt;
      r_tick       <= w_tick_nxt;
      r_seconds    <= w_seconds_nxt;
      r_minutes    <= w_minutes_nxt;
      r_timer      <= w_timer_nxt;
      r_timeout    <= w_timeout_nxt;
      r_best_valid <= w_best_valid_nxt;
      r_best_time  <= w_best_time_nxt;
    end
  end

  // Next state in priority order: abort, start, solved, tick/timeout, pause_toggle.
  always_comb begin
    w_state_nxt      = r_state;
    w_tick_nxt       = 1'b0;
    w_seconds_nxt    = r_seconds;
    w_minutes_nxt    = r_minutes;
    w_timer_nxt      = r_timer;
    w_best_valid_nxt = r_best_valid;
    w_best_time_nxt  = r_best_time;

    if (abort) begin
      w_state_nxt   = ST_IDLE;
      w_seconds_nxt = '0;
      w_minutes_nxt = '0;
      w_timer_nxt   = '0;
    end else if (w_start_ok) begin
      w_state_nxt   = ST_RUNNING;
      w_seconds_nxt = '0;
      w_minutes_nxt = '0;
      w_timer_nxt   = '0;
    end else if (w_solve_ok) begin
      w_state_nxt = ST_SOLVED;
      if (!r_best_valid || (r_timer < r_best_time)) begin
        w_best_valid_nxt = 1'b1;
        w_best_time_nxt  = r_timer;
      end
    end else begin
      if (w_wrap) begin
        w_tick_nxt  = 1'b1;
        w_timer_nxt = r_timer + TIMER_W'(1);
        if (r_seconds == SEC_MAX) begin
          w_seconds_nxt = '0;
          w_minutes_nxt = r_minutes + MIN_W'(1);
        end else begin
          w_seconds_nxt = r_seconds + SEC_W'(1);
        end
        if (w_timer_nxt == LIMIT_T) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      if (pause_toggle && (w_state_nxt != ST_TIMEOUT)) begin
        if (r_state == ST_RUNNING) begin
          w_state_nxt = ST_PAUSED;
        end else if (r_state == ST_PAUSED) begin
          w_state_nxt = ST_RUNNING;
        end
      end
    end

    w_running_nxt = (w_state_nxt == ST_RUNNING);
    w_timeout_nxt = (w_state_nxt == ST_TIMEOUT);
  end

  assign state      = r_state;
  assign running    = r_running;
  assign tick       = r_tick;
  assign seconds    = r_seconds;
  assign minutes    = r_minutes;
  assign timer      = r_timer;
  assign timeout    = r_timeout;
  assign best_valid = r_best_valid;
  assign best_time  = r_best_time;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl with CLK_HZ=4, LIMIT_MIN=2.
module tb_game_timer_ctrl;

  localparam int CLK_HZ    = 4;
  localparam int LIMIT_MIN = 2;
  localparam int LIMIT_CLK = LIMIT_MIN * 60 * CLK_HZ;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_SOLVED = 3, S_TOUT = 4;

  logic        clk;
  logic        reset_n;
  logic        start, pause_toggle, solved, abort;
  logic [2:0]  state;
  logic        running, tick, timeout, best_valid;
  logic [5:0]  seconds;
  logic [4:0]  minutes;
  logic [10:0] timer, best_time;

  int n_checks;
  int n_fail;
  int tick_seen;

  // Model: elapsed RUNNING clocks; displayed time is derived from it arithmetically.
  int m_state, m_elapsed, m_best;
  bit m_tick, m_bv;

  game_timer_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .LIMIT_MIN (LIMIT_MIN)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .pause_toggle (pause_toggle),
    .solved       (solved),
    .abort        (abort),
    .state        (state),
    .running      (running),
    .tick         (tick),
    .seconds      (seconds),
    .minutes      (minutes),
    .timer        (timer),
    .timeout      (timeout),
    .best_valid   (best_valid),
    .best_time    (best_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= S_IDLE; m_elapsed <= 0; m_tick <= 1'b0; m_best <= 0; m_bv <= 1'b0;
    end else begin
      int s, e, b;
      bit t, v;
      s = m_state; e = m_elapsed; b = m_best; v = m_bv; t = 1'b0;
      if (abort) begin
        s = S_IDLE; e = 0;
      end else if (start && (m_state == S_IDLE || m_state == S_SOLVED || m_state == S_TOUT)) begin
        s = S_RUN; e = 0;
      end else if (solved && (m_state == S_RUN || m_state == S_PAUSE)) begin
        s = S_SOLVED;
        if (!v || (e / CLK_HZ) < b) begin b = e / CLK_HZ; v = 1'b1; end
      end else begin
        if (m_state == S_RUN) begin
          e = e + 1;
          if (e % CLK_HZ == 0) t = 1'b1;
          if (e == LIMIT_CLK) s = S_TOUT;
        end
        if (pause_toggle && s != S_TOUT) begin
          if (m_state == S_RUN) s = S_PAUSE;
          else if (m_state == S_PAUSE) s = S_RUN;
        end
      end
      m_state <= s; m_elapsed <= e; m_tick <= t; m_best <= b; m_bv <= v;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int et;
    et = m_elapsed / CLK_HZ;
    n_checks++;
    if (int'(state) != m_state || running != (m_state == S_RUN) || tick != m_tick ||
        int'(seconds) != et % 60 || int'(minutes) != et / 60 || int'(timer) != et ||
        timeout != (m_state == S_TOUT) || best_valid != m_bv || int'(best_time) != m_best) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t act st=%0d run=%0b tick=%0b mm:ss=%0d:%0d tmr=%0d to=%0b bv=%0b bt=%0d exp st=%0d tick=%0b tmr=%0d bv=%0b bt=%0d",
               $time, state, running, tick, minutes, seconds, timer, timeout, best_valid, best_time,
               m_state, m_tick, et, m_bv, m_best);
    end
  end

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick) tick_seen++;
    end
  endtask

  // Drive {abort,start,solved,pause_toggle} for one clock, from a negedge.
  task automatic pulse(input logic [3:0] v);
    {abort, start, solved, pause_toggle} = v;
    @(negedge clk);
    {abort, start, solved, pause_toggle} = 4'b0000;
    if (tick) tick_seen++;
  endtask

  localparam logic [3:0] P_ABORT = 4'b1000, P_START = 4'b0100,
                         P_SOLVE = 4'b0010, P_PAUSE = 4'b0001;

  initial begin
    int tick_bad;
    n_checks = 0; n_fail = 0; tick_seen = 0;
    reset_n = 1'b0;
    {abort, start, solved, pause_toggle} = 4'b0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset mid-run
    pulse(P_START);
    wait_clks(10);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_state", int'(state), S_IDLE);
    check_eq("rst_timer", int'(timer), 0);
    check_eq("rst_outs", int'({running, tick, timeout, best_valid, seconds, minutes, best_time}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 2: 260 clocks of running gives 65 ticks, one every 4 clocks
    pulse(P_START);
    tick_seen = 0; tick_bad = 0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (tick) tick_seen++;
      if (tick != (i % 4 == 0)) tick_bad++;
    end
    check_eq("run_ticks", tick_seen, 65);
    check_eq("run_tick_period", tick_bad, 0);
    check_eq("run_seconds", int'(seconds), 5);
    check_eq("run_minutes", int'(minutes), 1);
    check_eq("run_timer", int'(timer), 65);

    // 3: pause keeps the partial second
    pulse(P_ABORT);
    pulse(P_START);
    wait_clks(5);
    pulse(P_PAUSE);
    check_eq("pause_state", int'(state), S_PAUSED_C());
    tick_seen = 0;
    wait_clks(19);
    check_eq("pause_no_ticks", tick_seen, 0);
    pulse(P_PAUSE);
    check_eq("resume_timer", int'(timer), 1);
    wait_clks(1);
    check_eq("resume_tick_early", int'(tick), 0);
    wait_clks(1);
    check_eq("resume_tick", int'(tick), 1);
    check_eq("resume_timer2", int'(timer), 2);

    // 4: time limit reached
    pulse(P_ABORT);
    pulse(P_START);
    wait_clks(479);
    check_eq("pre_timeout_timer", int'(timer), 119);
    wait_clks(1);
    check_eq("timeout_state", int'(state), S_TOUT);
    check_eq("timeout_mmss", int'(minutes) * 100 + int'(seconds), 200);
    check_eq("timeout_timer", int'(timer), 120);
    tick_seen = 0;
    wait_clks(500);
    check_eq("timeout_no_ticks", tick_seen, 0);
    pulse(P_SOLVE);
    check_eq("timeout_solve_ignored", int'(state), S_TOUT);
    check_eq("timeout_best_valid", int'(best_valid), 0);

    // 5: best time 40 -> 30 -> 30
    pulse(P_START);
    wait_clks(160);
    pulse(P_SOLVE);
    check_eq("best_first", int'(best_time), 40);
    pulse(P_START);
    wait_clks(120);
    pulse(P_SOLVE);
    check_eq("best_lower", int'(best_time), 30);
    pulse(P_START);
    wait_clks(140);
    pulse(P_SOLVE);
    check_eq("best_higher_kept", int'(best_time), 30);
    check_eq("best_valid", int'(best_valid), 1);

    // 6: solve on a wrap cycle, then abort+start together
    pulse(P_START);
    wait_clks(39);
    check_eq("prewrap_timer", int'(timer), 9);
    pulse(P_SOLVE);
    check_eq("wrap_solve_state", int'(state), S_SOLVED);
    check_eq("wrap_solve_timer", int'(timer), 9);
    check_eq("wrap_solve_tick", int'(tick), 0);
    check_eq("wrap_solve_best", int'(best_time), 9);
    pulse(P_ABORT | P_START);
    check_eq("abort_start_state", int'(state), S_IDLE);
    check_eq("abort_start_timer", int'(timer), 0);
    check_eq("abort_keeps_best", int'(best_time), 9);

    // Pause on a wrap cycle: tick counted, then paused
    pulse(P_START);
    wait_clks(3);
    pulse(P_PAUSE);
    check_eq("wrap_pause_tick", int'(tick), 1);
    check_eq("wrap_pause_timer", int'(timer), 1);
    check_eq("wrap_pause_state", int'(state), S_PAUSE);

    // Reset mid-game discards best time
    reset_n = 1'b0;
    #1;
    check_eq("rst_best_cleared", int'({best_valid, best_time}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clks(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  function automatic int S_PAUSED_C();
    return S_PAUSE;
  endfunction

endmodule
